cam_ctrl: RTL and testbench
===========================

Name: cam_ctrl

Overview:
Controller that shares one 14-entry 8-bit CAM between two requesters. It arbitrates round-robin, sequences the CAM's enable/write/addr/data pins, and allocates free CAM slots. It supports two operations: LOOKUP, and INSERT (insert the key only if it is absent). It sits between the requester logic and the CAM instance; CAM outputs feed back into it.

Parameters:
NB_MEM, 14, number of CAM entries; the allocation pointer saturates here.
SIZE_ADDR, 4, CAM index width; cam_addr is padded to 5 bits with a leading 0.

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
req_valid  in  2  per-requester request valid
req_ready  out  2  per-requester accept; one-hot or zero
req_op  in  2  per-requester op; 0 = LOOKUP, 1 = INSERT
req_data0  in  8  key from requester 0
req_data1  in  8  key from requester 1
rsp_valid  out  1  response valid
rsp_ready  in  1  response accept
rsp_id  out  1  requester that owns the response
rsp_idx  out  5  CAM index (hit index or newly written index)
rsp_hit  out  1  key was already present
rsp_full  out  1  INSERT missed and no free slot remains
cam_enable  out  1  CAM lookup strobe
cam_write  out  1  CAM write strobe
cam_addr  out  5  CAM write address
cam_data  out  8  CAM key
cam_out  in  5  CAM match index
cam_found  in  1  CAM match flag
alloc_cnt  out  5  number of slots allocated so far

Behaviour:
- Clocking and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset state: state=IDLE, req_ready=0, rsp_valid=0, rsp_*=0, cam_*=0, alloc_cnt=0, rr_last=1 (so requester 0 wins first).
- FSM states: IDLE, LOOK, WAIT, WR, RESP.
- IDLE:
  - If any req_valid is set, grant one requester: the one not equal to rr_last when both are valid, otherwise the only valid one.
  - Pulse req_ready for that requester for one cycle.
  - Latch op, key and id; update rr_last.
  - Go to LOOK.
- LOOK: cam_enable=1, cam_data=key for exactly one cycle; go to WAIT.
- WAIT (CAM result is registered, so it is valid now): sample cam_found and cam_out. Then:
  - LOOKUP: rsp_hit=cam_found, rsp_idx=cam_out; go to RESP.
  - INSERT with hit: rsp_hit=1, rsp_idx=cam_out; go to RESP.
  - INSERT with miss and alloc_cnt<NB_MEM: go to WR.
  - INSERT with miss and alloc_cnt==NB_MEM: rsp_full=1, rsp_idx=0; go to RESP.
- WR:
  - cam_write=1, cam_addr=alloc_cnt, cam_data=key for one cycle.
  - rsp_idx=alloc_cnt, rsp_hit=0; alloc_cnt increments by 1.
  - Go to RESP.
- RESP: rsp_valid=1. Hold all rsp_* stable until rsp_ready. On the rsp_valid&&rsp_ready cycle go to IDLE and clear rsp_valid.
- Back-to-back: a new grant happens no earlier than the cycle after the response handshake. Minimum latency from grant to rsp_valid: LOOKUP 3 cycles, INSERT-miss 4 cycles.
- Strobe exclusivity: cam_enable and cam_write are never high together. Both are 0 outside LOOK and WR.
- Width: alloc_cnt is 5 bits and saturates at NB_MEM; it never wraps. cam_addr[4] is always 0.
- Requester rules: req_valid may drop without a handshake. Key and op are sampled only on the grant cycle.
- Reset mid-operation:
  - All state returns to reset values.
  - Any in-flight response is lost.
  - CAM contents are not cleared, but alloc_cnt restarts at 0, so later inserts overwrite entries from index 0 upward.

Optional Feature:
CAM_CTRL_STATS_EN:
- When defined, adds outputs hit_cnt[15:0], miss_cnt[15:0] and full_cnt[15:0].
- Each counter increments by 1 in WAIT for the matching outcome. INSERT misses that lead to WR count as misses.
- Counters saturate at 16'hFFFF and reset to 0.
- When undefined, these ports and registers do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package cam_pkg:
  - state enum (IDLE/LOOK/WAIT/WR/RESP)
  - op constants OP_LOOKUP=0 and OP_INSERT=1
  - CAM_KEY_W=8 and CAM_IDX_W=5
- One natural sub-module: cam_rr_arb2, a 2-way round-robin arbiter that takes valid[1:0] and a grant-enable and returns grant[1:0] while holding rr_last.

Test Plan:
- Reset, then req0 INSERT 0xA5 → cam_write at addr 0; response idx=0, hit=0, full=0, id=0; alloc_cnt=1.
- req1 LOOKUP 0xA5 → response idx=0, hit=1, id=1; no cam_write pulse.
- INSERT 0xA5 again → hit=1, idx=0; alloc_cnt stays 1.
- Both requesters valid continuously with INSERT of distinct keys → grants alternate 0,1,0,1; responses carry matching rsp_id.
- Fill 14 distinct keys, then INSERT 0x3C → full=1, no cam_write; alloc_cnt=14.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and no new grant. Assert rst_n=0 during WAIT → next cycle rsp_valid=0, state IDLE, alloc_cnt=0.

Source files
------------

// File: rtl/cam_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// cam_pkg
// Shared definitions for the CAM controller slice: FSM state encoding,
// request opcodes, key/index widths and a saturating counter helper.
// ---------------------------------------------------------------------------
package cam_pkg;

  localparam int CAM_KEY_W = 8;
  localparam int CAM_IDX_W = 5;

  localparam logic OP_LOOKUP = 1'b0;
  localparam logic OP_INSERT = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOOK,
    WAIT,
    WR,
    RESP
  } state_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/cam_ctrl_if.sv
// ---------------------------------------------------------------------------
// cam_ctrl_if
// Requester/response bundle of the CAM controller.
//   req_valid[1:0]  per-requester request valid
//   req_ready[1:0]  per-requester accept (one-hot or zero)
//   req_op[1:0]     per-requester op (0 = LOOKUP, 1 = INSERT)
//   req_data0/1     8-bit keys of requester 0 / 1
//   rsp_valid/ready response handshake
//   rsp_id          requester owning the response
//   rsp_idx         CAM index (hit index or newly written index)
//   rsp_hit         key was already present
//   rsp_full        INSERT missed and no free slot remains
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface cam_ctrl_if;
  import cam_pkg::*;

  logic [1:0]           req_valid;
  logic [1:0]           req_ready;
  logic [1:0]           req_op;
  logic [CAM_KEY_W-1:0] req_data0;
  logic [CAM_KEY_W-1:0] req_data1;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic                 rsp_id;
  logic [CAM_IDX_W-1:0] rsp_idx;
  logic                 rsp_hit;
  logic                 rsp_full;

  modport master (
    output req_valid, req_op, req_data0, req_data1, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_idx, rsp_hit, rsp_full
  );

  modport slave (
    input  req_valid, req_op, req_data0, req_data1, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_idx, rsp_hit, rsp_full
  );

endinterface

// File: rtl/cam_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// cam_rr_arb2
// Two-way round-robin arbiter.
//   clk, rst_n  clock, synchronous active-low reset
//   valid[1:0]  request lines
//   grant_en    arbitration allowed this cycle
//   grant[1:0]  one-hot grant or zero (combinational)
// rr_last remembers the last winner; it resets to 1 so requester 0 wins
// the first contested round.
// ---------------------------------------------------------------------------
module cam_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       grant_en,
  output logic [1:0] grant
);

  logic rr_last;

  // On contention the requester that did not win last time gets the grant.
  always_comb begin
    grant = 2'b00;
    if (grant_en) begin
      if (valid == 2'b11) grant = rr_last ? 2'b01 : 2'b10;
      else                grant = valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      rr_last <= 1'b1;
    else if (|grant) rr_last <= grant[1];
  end

endmodule

// File: rtl/cam_ctrl.sv
// ---------------------------------------------------------------------------
// cam_ctrl
// Shares one 14-entry, 8-bit-key CAM between two requesters. Arbitrates
// round-robin, drives the CAM lookup/write pins, and hands out free slots
// in order (LOOKUP, and INSERT-if-absent).
//   clk, rst_n    clock, synchronous active-low reset
//   bus           cam_ctrl_if.slave request/response bundle
//   cam_enable    CAM lookup strobe (LOOK state only)
//   cam_write     CAM write strobe (WR state only)
//   cam_addr[4:0] CAM write address, bit 4 always 0
//   cam_data[7:0] CAM key
//   cam_out[4:0]  CAM match index (registered by the CAM)
//   cam_found     CAM match flag (registered by the CAM)
//   alloc_cnt     slots allocated so far, saturates at NB_MEM
// Optional macro CAM_CTRL_STATS_EN adds hit_cnt/miss_cnt/full_cnt.
// CAM contents survive reset while alloc_cnt does not, so inserts after a
// reset overwrite slots from index 0 upward.
// ---------------------------------------------------------------------------
module cam_ctrl
  import cam_pkg::*;
#(
  parameter int NB_MEM    = 14,
  parameter int SIZE_ADDR = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cam_ctrl_if.slave            bus,
  output logic                 cam_enable,
  output logic                 cam_write,
  output logic [CAM_IDX_W-1:0] cam_addr,
  output logic [CAM_KEY_W-1:0] cam_data,
  input  logic [CAM_IDX_W-1:0] cam_out,
  input  logic                 cam_found,
  output logic [CAM_IDX_W-1:0] alloc_cnt
`ifdef CAM_CTRL_STATS_EN
  ,
  output logic [15:0]          hit_cnt,
  output logic [15:0]          miss_cnt,
  output logic [15:0]          full_cnt
`endif
);

  localparam logic [CAM_IDX_W-1:0] ALLOC_MAX = CAM_IDX_W'(NB_MEM);

  state_t               state, state_nxt;
  logic                 op_q;
  logic [CAM_KEY_W-1:0] key_q;
  logic [1:0]           grant;
  logic                 alloc_avail;

  assign alloc_avail = (alloc_cnt < ALLOC_MAX);

  cam_rr_arb2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .valid    (bus.req_valid),
    .grant_en (state == IDLE),
    .grant    (grant)
  );

  // Next state plus the combinational strobes. The CAM registers its
  // result, so the match is only looked at one cycle after LOOK.
  always_comb begin
    state_nxt     = state;
    bus.req_ready = grant;
    bus.rsp_valid = (state == RESP);
    cam_enable    = (state == LOOK);
    cam_write     = (state == WR);
    cam_addr      = '0;
    cam_data      = '0;
    case (state)
      IDLE: if (|grant) state_nxt = LOOK;
      LOOK: begin
        cam_data  = key_q;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (op_q == OP_INSERT && !cam_found && alloc_avail) state_nxt = WR;
        else                                                state_nxt = RESP;
      end
      WR: begin
        cam_addr  = CAM_IDX_W'(alloc_cnt[SIZE_ADDR-1:0]);
        cam_data  = key_q;
        state_nxt = RESP;
      end
      RESP: if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, request capture and response fields. Response fields
  // are only written before RESP, so they stay stable while it stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      op_q         <= OP_LOOKUP;
      key_q        <= '0;
      alloc_cnt    <= '0;
      bus.rsp_id   <= 1'b0;
      bus.rsp_idx  <= '0;
      bus.rsp_hit  <= 1'b0;
      bus.rsp_full <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (|grant) begin
            op_q         <= bus.req_op[grant[1]];
            key_q        <= grant[1] ? bus.req_data1 : bus.req_data0;
            bus.rsp_id   <= grant[1];
            bus.rsp_idx  <= '0;
            bus.rsp_hit  <= 1'b0;
            bus.rsp_full <= 1'b0;
          end
        end
        WAIT: begin
          if (op_q == OP_LOOKUP || cam_found) begin
            bus.rsp_hit <= cam_found;
            bus.rsp_idx <= cam_out;
          end else if (!alloc_avail) begin
            bus.rsp_full <= 1'b1;
            bus.rsp_idx  <= '0;
          end
        end
        WR: begin
          bus.rsp_idx <= alloc_cnt;
          bus.rsp_hit <= 1'b0;
          alloc_cnt   <= alloc_cnt + CAM_IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CAM_CTRL_STATS_EN
  // Outcome counters, bumped once per request when the CAM result lands.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      full_cnt <= '0;
    end else if (state == WAIT) begin
      if (cam_found)                            hit_cnt  <= sat_inc16(hit_cnt);
      else if (op_q == OP_LOOKUP || alloc_avail) miss_cnt <= sat_inc16(miss_cnt);
      else                                      full_cnt <= sat_inc16(full_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_cam_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cam_ctrl
// Bench for cam_ctrl: a behavioural registered CAM, a request-level model
// of the controller compared every cycle, and directed scenarios with
// hand-computed literal expectations.
// ---------------------------------------------------------------------------
module tb_cam_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cam_enable, cam_write;
  logic [4:0] cam_addr, alloc_cnt;
  logic [7:0] cam_data;
  logic [4:0] cam_out = '0;
  logic       cam_found = 1'b0;
`ifdef CAM_CTRL_STATS_EN
  logic [15:0] hit_cnt, miss_cnt, full_cnt;
`endif

  int  tests = 0;
  int  fails = 0;
  bit  check_en = 1'b0;

  logic [4:0] r_idx;
  logic       r_hit, r_full, r_id;
  int         r_lat;

  cam_ctrl_if bus();

  cam_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .cam_enable (cam_enable),
    .cam_write  (cam_write),
    .cam_addr   (cam_addr),
    .cam_data   (cam_data),
    .cam_out    (cam_out),
    .cam_found  (cam_found),
    .alloc_cnt  (alloc_cnt)
`ifdef CAM_CTRL_STATS_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt),
    .full_cnt   (full_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Round-robin rule: on contention the requester that did not win last.
  function automatic bit pick(input logic [1:0] v, input bit rr);
    if (v == 2'b11) return ~rr;
    return v[1];
  endfunction

  // Registered CAM: match result appears the cycle after cam_enable,
  // lowest matching index wins, contents are never cleared.
  logic [7:0] env_key[16];
  bit         env_val[16];
  always @(posedge clk) begin
    if (cam_write) begin
      env_key[cam_addr[3:0]] <= cam_data;
      env_val[cam_addr[3:0]] <= 1'b1;
    end
    if (cam_enable) begin
      cam_found <= 1'b0;
      cam_out   <= '0;
      for (int i = 15; i >= 0; i--)
        if (env_val[i] && env_key[i] == cam_data) begin
          cam_found <= 1'b1;
          cam_out   <= 5'(i);
        end
    end
  end

  // Request-level model: on a grant it decides the whole outcome from its
  // own slot table, then only tracks how many cycles have elapsed.
  bit         m_busy = 1'b0, m_rr = 1'b1, m_wr, m_id, m_hit, m_full;
  int         m_phase = 0, m_lat = 3, m_cnt = 0;
  logic [4:0] m_idx;
  logic [7:0] m_key;
  logic [7:0] m_mem[14];
  bit         m_val[14];

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_busy = 1'b0; m_rr = 1'b1; m_cnt = 0; m_phase = 0;
    end else if (m_busy) begin
      if (m_phase >= m_lat && bus.rsp_ready) m_busy = 1'b0;
      else if (m_phase < m_lat)              m_phase++;
    end else if (bus.req_valid != 2'b00) begin
      bit found;
      m_id  = pick(bus.req_valid, m_rr);
      m_rr  = m_id;
      m_key = m_id ? bus.req_data1 : bus.req_data0;
      found = 1'b0; m_idx = '0;
      for (int i = 13; i >= 0; i--)
        if (m_val[i] && m_mem[i] == m_key) begin found = 1'b1; m_idx = 5'(i); end
      m_wr = 1'b0; m_hit = found; m_full = 1'b0; m_lat = 3;
      if (!found && bus.req_op[m_id]) begin
        if (m_cnt < 14) begin
          m_wr = 1'b1; m_idx = 5'(m_cnt); m_lat = 4;
          m_mem[m_cnt] = m_key; m_val[m_cnt] = 1'b1; m_cnt++;
        end else m_full = 1'b1;
      end
      m_busy = 1'b1; m_phase = 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (check_en) begin
      logic [1:0] er;
      bit         ev;
      er = (!m_busy && bus.req_valid != 2'b00) ?
           (pick(bus.req_valid, m_rr) ? 2'b10 : 2'b01) : 2'b00;
      ev = m_busy && m_phase >= m_lat;
      checkOutput("req_ready", bus.req_ready, er);
      checkOutput("cam_enable", cam_enable, m_busy && m_phase == 1);
      checkOutput("cam_write", cam_write, m_busy && m_wr && m_phase == 3);
      checkOutput("cam_addr_msb", cam_addr[4], 1'b0);
      if (m_busy && m_phase == 1) checkOutput("cam_data_look", cam_data, m_key);
      if (m_busy && m_wr && m_phase == 3) begin
        checkOutput("cam_addr", cam_addr, m_idx);
        checkOutput("cam_data_wr", cam_data, m_key);
      end
      checkOutput("rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        checkOutput("rsp_id", bus.rsp_id, m_id);
        checkOutput("rsp_idx", bus.rsp_idx, m_idx);
        checkOutput("rsp_hit", bus.rsp_hit, m_hit);
        checkOutput("rsp_full", bus.rsp_full, m_full);
      end
      checkOutput("alloc_cnt", alloc_cnt,
                  m_cnt - ((m_busy && m_wr && m_phase < 4) ? 1 : 0));
    end
  end

  // Issue one request, wait for its grant and response (bounded), and
  // capture the response plus grant-to-response latency in r_*.
  task automatic applyStimulus(input bit id, input bit op, input logic [7:0] key);
    bit got;
    r_idx = '0; r_hit = 1'b0; r_full = 1'b0; r_id = 1'b0; r_lat = 0;
    @(posedge clk); #1;
    bus.req_op[id] = op;
    if (id) bus.req_data1 = key; else bus.req_data0 = key;
    bus.req_valid[id] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[id]) got = 1'b1;
    end
    if (!got) begin
      checkOutput("grant_timeout", 0, 1);
      bus.req_valid[id] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[id] = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      r_lat++;
      if (bus.rsp_valid) begin
        got = 1'b1;
        r_idx = bus.rsp_idx; r_hit = bus.rsp_hit; r_full = bus.rsp_full; r_id = bus.rsp_id;
      end
    end
    if (!got) checkOutput("rsp_timeout", 0, 1);
  endtask

  task automatic checkRsp(input string name, input int idx, input bit hit, input bit full,
                          input bit id, input int lat);
    checkOutput({name, "_idx"}, r_idx, idx);
    checkOutput({name, "_hit"}, r_hit, hit);
    checkOutput({name, "_full"}, r_full, full);
    checkOutput({name, "_id"}, r_id, id);
    checkOutput({name, "_lat"}, r_lat, lat);
  endtask

  task automatic waitRsp();
    bit got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) got = 1'b1;
    end
    if (!got) checkOutput("rsp_wait_timeout", 0, 1);
  endtask

  // Directed scenarios.
  initial begin
    bit         got, who;
    logic [7:0] nk;
    bus.req_valid = 2'b00; bus.req_op = 2'b00;
    bus.req_data0 = '0; bus.req_data1 = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_ready", bus.req_ready, 2'b00);
    checkOutput("reset_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("reset_cam_enable", cam_enable, 1'b0);
    checkOutput("reset_alloc", alloc_cnt, 0);

    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkRsp("ins_a5", 0, 1'b0, 1'b0, 1'b0, 4);
    checkOutput("alloc_after_ins", alloc_cnt, 1);
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkRsp("look_a5", 0, 1'b1, 1'b0, 1'b1, 3);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    checkRsp("reins_a5", 0, 1'b1, 1'b0, 1'b0, 3);
    checkOutput("alloc_after_reins", alloc_cnt, 1);
    applyStimulus(1'b1, 1'b0, 8'h77);
    checkRsp("look_miss", 0, 1'b0, 1'b0, 1'b1, 3);

    // Both requesters inserting continuously: grants must alternate.
    @(posedge clk); #1;
    bus.req_op = 2'b11; bus.req_data0 = 8'h11; bus.req_data1 = 8'h22;
    bus.req_valid = 2'b11; nk = 8'h40;
    for (int g = 0; g < 4; g++) begin
      got = 1'b0; who = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
        @(negedge clk);
        if (bus.req_ready != 2'b00) begin got = 1'b1; who = bus.req_ready[1]; end
      end
      if (!got) begin checkOutput("rr_timeout", 0, 1); break; end
      checkOutput("rr_order", who, g % 2);
      @(posedge clk); #1;
      if (who) bus.req_data1 = nk; else bus.req_data0 = nk;
      nk++;
    end
    bus.req_valid = 2'b00;
    waitRsp();
    checkOutput("alloc_after_rr", alloc_cnt, 5);

    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'(k % 2), 1'b1, 8'h50 + 8'(k));
      checkOutput("fill_idx", r_idx, 5 + k);
    end
    checkOutput("alloc_full", alloc_cnt, 14);
    applyStimulus(1'b0, 1'b1, 8'h3C);
    checkRsp("ins_full", 0, 1'b0, 1'b1, 1'b0, 3);
    checkOutput("alloc_sat", alloc_cnt, 14);

    // Stall the response with requester 1 waiting: nothing may move.
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 8'h50);
    checkRsp("look_hold", 5, 1'b1, 1'b0, 1'b0, 3);
    @(posedge clk); #1;
    bus.req_op[1] = 1'b0; bus.req_data1 = 8'h22; bus.req_valid[1] = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("hold_valid", bus.rsp_valid, 1'b1);
    checkOutput("hold_idx", bus.rsp_idx, 5);
    checkOutput("hold_no_grant", bus.req_ready, 2'b00);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1; bus.req_valid[1] = 1'b0;

    // Reset while the controller waits on the CAM result.
    @(posedge clk); #1;
    bus.req_op[0] = 1'b0; bus.req_data0 = 8'hA5; bus.req_valid[0] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.req_ready[0]) got = 1'b1;
    end
    if (!got) checkOutput("rst_grant_timeout", 0, 1);
    @(posedge clk); #1 bus.req_valid[0] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_rsp_valid", bus.rsp_valid, 1'b0);
    checkOutput("midrst_alloc", alloc_cnt, 0);
    checkOutput("midrst_ready", bus.req_ready, 2'b00);

    // After reset the slot pointer restarts while old entries persist.
    applyStimulus(1'b0, 1'b1, 8'h99);
    checkRsp("ins_after_rst", 0, 1'b0, 1'b0, 1'b0, 4);
    applyStimulus(1'b1, 1'b0, 8'hA5);
    checkRsp("look_overwritten", 0, 1'b0, 1'b0, 1'b1, 3);
    applyStimulus(1'b1, 1'b0, 8'h11);
    checkRsp("look_stale", 1, 1'b1, 1'b0, 1'b1, 3);
    @(posedge clk);
    @(negedge clk);

    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
